axi_wr_arbiter: RTL and testbench

Two-requester round-robin arbiter for a single AXI3 write path (AW, W and B channels) driving one downstream slave.
- Grants one requester a whole transaction: address, then all data beats, then the response. The grant is released only after the B handshake.
- Generates wlast and wid itself, so requesters do not supply them.
- Sits between the testbench or DMA masters and the slave side of axi_if.

---
 rtl/axi_wr_arbiter_if.sv | 67 ++++++
 rtl/axi_wr_arbiter.sv | 150 +++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_arbiter_if.sv
// Bundle of the two-requester upstream ports and the single downstream AXI3
// write channel (AW, W, B) seen by axi_wr_arbiter.
interface axi_wr_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4
);
  localparam int STRB_W = DATA_W / 8;

  // Handshake rule on every channel: a transfer happens on a rising clk edge
  // where valid and ready are both 1; once valid is raised, the payload holds
  // steady until that edge.

  // Requester side, lane i at [i*W +: W]
  logic [1:0]          req_awvalid;
  logic [1:0]          req_awready;
  logic [2*ADDR_W-1:0] req_awaddr;
  logic [2*LEN_W-1:0]  req_awlen;
  logic [5:0]          req_awsize;
  logic [3:0]          req_awburst;
  logic [2*ID_W-1:0]   req_awid;
  logic [1:0]          req_wvalid;
  logic [1:0]          req_wready;
  logic [2*DATA_W-1:0] req_wdata;
  logic [2*STRB_W-1:0] req_wstrb;
  logic [1:0]          req_bvalid;
  logic [1:0]          req_bready;
  logic [1:0]          req_bresp;

  // Downstream slave side
  logic              awvalid;
  logic              awready;
  logic [ID_W-1:0]   awid;
  logic [LEN_W-1:0]  awlen;
  logic [2:0]        awsize;
  logic [ADDR_W-1:0] awaddr;
  logic [1:0]        awburst;
  logic              wvalid;
  logic              wready;
  logic [ID_W-1:0]   wid;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              bvalid;
  logic              bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;

  modport master (
    input  req_awvalid, req_awaddr, req_awlen, req_awsize, req_awburst, req_awid,
    input  req_wvalid, req_wdata, req_wstrb, req_bready,
    output req_awready, req_wready, req_bvalid, req_bresp,
    output awvalid, awid, awlen, awsize, awaddr, awburst,
    output wvalid, wid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid, bid, bresp
  );

  modport slave (
    output req_awvalid, req_awaddr, req_awlen, req_awsize, req_awburst, req_awid,
    output req_wvalid, req_wdata, req_wstrb, req_bready,
    input  req_awready, req_wready, req_bvalid, req_bresp,
    input  awvalid, awid, awlen, awsize, awaddr, awburst,
    input  wvalid, wid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bid, bresp
  );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter granting one of two requesters a whole AXI3 write
// transaction (AW, all W beats, B); wlast and wid are generated here.
module axi_wr_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  axi_wr_arbiter_if.master bus,
  output logic             grant,
  output logic             busy,
  output logic             bid_err,
  output logic [1:0]       state_dbg
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [ID_W-1:0]  id_q, id_d;

  logic [ADDR_W-1:0] g_awaddr;
  logic [LEN_W-1:0]  g_awlen;
  logic [2:0]        g_awsize;
  logic [1:0]        g_awburst;
  logic [ID_W-1:0]   g_awid;
  logic [DATA_W-1:0] g_wdata;
  logic [STRB_W-1:0] g_wstrb;
  logic              g_wvalid;
  logic              g_bready;
  logic              last_beat;

  // Payload of the granted requester
  assign g_awaddr  = grant_q ? bus.req_awaddr[2*ADDR_W-1:ADDR_W] : bus.req_awaddr[ADDR_W-1:0];
  assign g_awlen   = grant_q ? bus.req_awlen[2*LEN_W-1:LEN_W]    : bus.req_awlen[LEN_W-1:0];
  assign g_awsize  = grant_q ? bus.req_awsize[5:3]               : bus.req_awsize[2:0];
  assign g_awburst = grant_q ? bus.req_awburst[3:2]              : bus.req_awburst[1:0];
  assign g_awid    = grant_q ? bus.req_awid[2*ID_W-1:ID_W]       : bus.req_awid[ID_W-1:0];
  assign g_wdata   = grant_q ? bus.req_wdata[2*DATA_W-1:DATA_W]  : bus.req_wdata[DATA_W-1:0];
  assign g_wstrb   = grant_q ? bus.req_wstrb[2*STRB_W-1:STRB_W]  : bus.req_wstrb[STRB_W-1:0];
  assign g_wvalid  = bus.req_wvalid[grant_q];
  assign g_bready  = bus.req_bready[grant_q];
  assign last_beat = (beat_cnt_q == len_q);

  assign grant     = grant_q;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      len_q        <= '0;
      id_q         <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      len_q        <= len_d;
      id_q         <= id_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    beat_cnt_d      = beat_cnt_q;
    len_d           = len_q;
    id_d            = id_q;
    bid_err         = 1'b0;
    bus.req_awready = 2'b00;
    bus.req_wready  = 2'b00;
    bus.req_bvalid  = 2'b00;
    bus.req_bresp   = bus.bresp;
    bus.awvalid     = 1'b0;
    bus.awid        = '0;
    bus.awlen       = '0;
    bus.awsize      = '0;
    bus.awaddr      = '0;
    bus.awburst     = '0;
    bus.wvalid      = 1'b0;
    bus.wid         = '0;
    bus.wdata       = '0;
    bus.wstrb       = '0;
    bus.wlast       = 1'b0;
    bus.bready      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|bus.req_awvalid) begin
          // Contention goes to the requester that did not win last time
          grant_d = (&bus.req_awvalid) ? ~last_grant_q : bus.req_awvalid[1];
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        bus.awvalid              = 1'b1;
        bus.awid                 = g_awid;
        bus.awlen                = g_awlen;
        bus.awsize               = g_awsize;
        bus.awaddr               = g_awaddr;
        bus.awburst              = g_awburst;
        bus.req_awready[grant_q] = bus.awready;
        if (bus.awready) begin
          len_d      = g_awlen;
          id_d       = g_awid;
          beat_cnt_d = '0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        bus.wvalid              = g_wvalid;
        bus.wid                 = id_q;
        bus.wdata               = g_wdata;
        bus.wstrb               = g_wstrb;
        bus.wlast               = last_beat;
        bus.req_wready[grant_q] = bus.wready;
        if (g_wvalid && bus.wready) begin
          if (last_beat) state_d = S_RESP;
          else           beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        bus.req_bvalid[grant_q] = bus.bvalid;
        bus.bready              = g_bready;
        if (bus.bvalid && g_bready) begin
          bid_err      = (bus.bid != id_q);
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: a table of whole transactions plus a
// hand-written mid-burst reset sequence; W beats are scored from a queue.
module tb_axi_wr_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 4;
  localparam int STRB_W = DATA_W / 8;
  localparam int SB_W   = ID_W + 1 + DATA_W;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       grant, busy, bid_err;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  axi_wr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) bus ();

  axi_wr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .grant     (grant),
    .busy      (busy),
    .bid_err   (bid_err),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [SB_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Every accepted downstream beat must match the next expected {wid, wlast, wdata}
  always @(negedge clk) begin
    if (!reset && bus.wvalid === 1'b1 && bus.wready === 1'b1) begin
      logic            have;
      logic [SB_W-1:0] e;
      have = (exp_q.size() != 0);
      e    = have ? exp_q.pop_front() : '0;
      chk("w_beat", {1'b1, bus.wid, bus.wlast, bus.wdata}, {have, e});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_awvalid = '0; bus.req_awaddr = '0; bus.req_awlen = '0;
    bus.req_awsize  = '0; bus.req_awburst = '0; bus.req_awid = '0;
    bus.req_wvalid  = '0; bus.req_wdata = '0; bus.req_wstrb = '0;
    bus.req_bready  = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
    bus.bid = '0; bus.bresp = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Entered in IDLE; leaves with AW accepted and the DUT in DATA
  task automatic addr_phase(input logic [1:0] reqs, input int gi, input logic [ADDR_W-1:0] addr,
                            input logic [LEN_W-1:0] len, input logic [ID_W-1:0] id);
    bus.req_awaddr[gi*ADDR_W +: ADDR_W] = addr;
    bus.req_awlen[gi*LEN_W +: LEN_W]    = len;
    bus.req_awid[gi*ID_W +: ID_W]       = id;
    bus.req_awsize[gi*3 +: 3]           = 3'd2;
    bus.req_awburst[gi*2 +: 2]          = 2'b01;
    bus.req_awvalid = bus.req_awvalid | reqs;
    bus.awready     = 1'b1;
    #1;
    chk("idle_awvalid", bus.awvalid, 0);
    chk("idle_busy", busy, 0);
    cycle();
    chk("grant", grant, gi);
    chk("addr_busy", busy, 1);
    chk("awvalid", bus.awvalid, 1);
    chk("awaddr", bus.awaddr, addr);
    chk("awlen", bus.awlen, len);
    chk("awid", bus.awid, id);
    chk("awsize", bus.awsize, 2);
    chk("awburst", bus.awburst, 1);
    chk("req_awready", bus.req_awready, 64'd1 << gi);
    cycle();
    bus.req_awvalid[gi] = 1'b0;
    bus.awready         = 1'b0;
    #1;
    chk("aw_done", bus.awvalid, 0);
  endtask

  // Drives beats until max_beats are accepted or the cycle budget runs out
  task automatic data_phase(input int gi, input logic [LEN_W-1:0] len, input logic [ID_W-1:0] id,
                            input logic [DATA_W-1:0] base, input bit toggle, input bit stall,
                            input int max_beats);
    int   beats = 0;
    int   n = 0;
    int   stall_cnt = 0;
    logic v;
    for (int i = 0; i <= int'(len); i++)
      exp_q.push_back({id, 1'(i == int'(len)), DATA_W'(base + DATA_W'(i))});
    while (beats < max_beats && n < 200) begin
      bus.wready = toggle ? (n % 2 == 0) : 1'b1;
      v = !(stall && beats == 2 && stall_cnt < 5);
      if (!v) stall_cnt++;
      bus.req_wvalid[gi] = v;
      bus.req_wdata[gi*DATA_W +: DATA_W] = base + DATA_W'(beats);
      bus.req_wstrb[gi*STRB_W +: STRB_W] = gi[0] ? 4'h3 : 4'hC;
      #1;
      chk("wvalid", bus.wvalid, v);
      chk("req_wready", bus.req_wready, 64'(bus.wready) << gi);
      chk("other_awready", bus.req_awready, 0);
      chk("wstrb", bus.wstrb, gi[0] ? 4'h3 : 4'hC);
      if (v && bus.wready) beats++;
      n++;
      cycle();
    end
    bus.req_wvalid[gi] = 1'b0;
    bus.wready         = 1'b0;
    chk("beats_accepted", beats, max_beats);
  endtask

  task automatic resp_phase(input int gi, input logic [ID_W-1:0] bid_v,
                            input logic [1:0] bresp_v, input logic exp_err);
    bus.req_bready[gi] = 1'b1;
    bus.bvalid = 1'b0;
    #1;
    chk("resp_busy", busy, 1);
    chk("req_bvalid_wait", bus.req_bvalid, 0);
    chk("bready", bus.bready, 1);
    chk("beats_left", exp_q.size(), 0);
    cycle();
    bus.bvalid = 1'b1;
    bus.bid    = bid_v;
    bus.bresp  = bresp_v;
    #1;
    chk("req_bvalid", bus.req_bvalid, 64'd1 << gi);
    chk("req_bresp", bus.req_bresp, bresp_v);
    chk("bid_err", bid_err, exp_err);
    cycle();
    bus.bvalid = 1'b0;
    bus.bid    = '0;
    bus.req_bready[gi] = 1'b0;
    #1;
    chk("bid_err_pulse", bid_err, 0);
    chk("released", busy, 0);
    chk("req_bvalid_off", bus.req_bvalid, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit               rst;
    logic [1:0]       reqs;
    logic             g;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0] len;
    logic [ID_W-1:0]  id;
    logic [ID_W-1:0]  bid;
    logic [1:0]       bresp;
    bit               toggle;
    bit               stall;
    logic             exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 2'b01, 1'b0, 32'h0000_0100, 4'd3,  4'd2, 4'd2, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 2'b11, 1'b0, 32'h0000_0200, 4'd1,  4'd1, 4'd1, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 2'b00, 1'b1, 32'h0000_0300, 4'd2,  4'd6, 4'd6, 2'b10, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 2'b11, 1'b0, 32'h0000_0400, 4'd0,  4'd4, 4'd4, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 2'b00, 1'b1, 32'h0000_0500, 4'd0,  4'd7, 4'd7, 2'b11, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 2'b01, 1'b0, 32'h0000_0600, 4'd15, 4'd9, 4'd9, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 2'b11, 1'b1, 32'h0000_0800, 4'd3,  4'd8, 4'd8, 2'b00, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 2'b00, 1'b0, 32'h0000_0900, 4'd3,  4'd3, 4'd5, 2'b10, 1'b0, 1'b0, 1'b1};

    // Reset state while reset is held
    clear_inputs();
    @(posedge clk);
    #1;
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_bready", bus.bready, 0);
    chk("rst_req_awready", bus.req_awready, 0);
    chk("rst_req_wready", bus.req_wready, 0);
    chk("rst_req_bvalid", bus.req_bvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_bid_err", bid_err, 0);
    chk("rst_awaddr", bus.awaddr, 0);
    chk("rst_awid", bus.awid, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_wid", bus.wid, 0);
    chk("rst_state", state_dbg, 0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rst) do_reset();
      addr_phase(vecs[i].reqs, int'(vecs[i].g), vecs[i].addr, vecs[i].len, vecs[i].id);
      data_phase(int'(vecs[i].g), vecs[i].len, vecs[i].id, vecs[i].addr + 32'hD000_0000,
                 vecs[i].toggle, vecs[i].stall, int'(vecs[i].len) + 1);
      resp_phase(int'(vecs[i].g), vecs[i].bid, vecs[i].bresp, vecs[i].exp_err);
    end

    // Reset during DATA after 2 of 4 beats: outputs drop without waiting for a clock
    do_reset();
    addr_phase(2'b01, 0, 32'h0000_0700, 4'd3, 4'hA);
    data_phase(0, 4'd3, 4'hA, 32'hD000_0700, 1'b0, 1'b0, 2);
    bus.req_wvalid[0] = 1'b1;
    bus.wready        = 1'b1;
    #1;
    chk("pre_rst_wvalid", bus.wvalid, 1);
    reset = 1'b1;
    #1;
    chk("arst_wvalid", bus.wvalid, 0);
    chk("arst_req_wready", bus.req_wready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_grant", grant, 0);
    chk("arst_wdata", bus.wdata, 0);
    chk("arst_wid", bus.wid, 0);
    chk("arst_state", state_dbg, 0);
    exp_q.delete();
    clear_inputs();
    bus.req_awvalid = 2'b11;
    @(negedge clk);
    reset = 1'b0;
    cycle();
    chk("post_rst_grant", grant, 0);
    chk("post_rst_awvalid", bus.awvalid, 1);
    chk("post_rst_req_bvalid", bus.req_bvalid, 0);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, %0d of %0d checks passed so far", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end
endmodule
